// File: rtl/fifo_pkg.sv
// Shared FIFO package: default sizing constants, the registered status-flag
// bundle, and the pointer-width helper used by the FIFO, its RAM and its bus.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_DEPTH     = 8;
    // almost_full defaults to DEPTH minus this margin
    localparam int unsigned DEF_AF_MARGIN = 2;
    localparam int unsigned DEF_AE_THRESH = 2;

    // Registered occupancy/threshold flags, updated together every cycle
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Ceiling log2; constant-evaluable so it can size parameters and ports
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// FIFO bus: write/read requests, data in/out, status flags and error pulses.
//   master : drives wr, rd, data_in; observes everything else
//   slave  : the FIFO; drives data_out, full, empty, almost_full,
//            almost_empty, count, overflow, underflow
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned CW = clog2(DEPTH) + 1;

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, rd, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage, WIDTH x DEPTH: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address      wdata : write data
//   raddr : read address       rdata : read data (combinational)
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive reset; the FIFO pointers decide what is valid
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered full/empty/almost flags, occupancy count
// and one-cycle overflow/underflow pulses.
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : sync_fifo_flags_if.slave (wr, rd, data_in, data_out, flags, count,
//         overflow, underflow)
// Build option SYNC_FIFO_FWFT_EN: first-word-fall-through (data_out shows the
// head entry combinationally); otherwise data_out is loaded on each accepted
// read with one cycle of latency.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH
)(
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    fifo_flags_t      flags_q,  flags_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Acceptance, next pointers/count and next flags; flags are computed from
    // next-state so the registered copies stay consistent with count.
    always_comb begin
        rd_acc = bus.rd & ~flags_q.empty;
        // A full FIFO still takes a write when a read frees a slot this cycle
        wr_acc = bus.wr & (~flags_q.full | rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);

        flags_d.full         = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        flags_d.empty        = (wr_ptr_d == rd_ptr_d);
        flags_d.almost_full  = (count_d >= CW'(AF_THRESH));
        flags_d.almost_empty = (count_d <= CW'(AE_THRESH));

        overflow_d  = bus.wr & flags_q.full & ~rd_acc;
        underflow_d = bus.rd & flags_q.empty;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flags_q     <= '{full: 1'b0, empty: 1'b1,
                             almost_full: 1'b0, almost_empty: 1'b1};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry falls through; content is meaningless while empty
    assign bus.data_out = ram_rdata;
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    // Capture the head word on an accepted read, otherwise hold
    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.full         = flags_q.full;
    assign bus.empty        = flags_q.empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: the driver applies directed and
// random wr/rd traffic, a queue-based reference model predicts the state
// after each clock edge, and a monitor compares on the following falling edge.
module tb_sync_fifo_flags;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_flags #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         count;
        bit         full;
        bit         empty;
        bit         af;
        bit         ae;
        bit         ov;
        bit         un;
        bit         dchk;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[$];
    logic [7:0] mdout;
    int         checks = 0;
    int         errors = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endfunction

    // One clock of stimulus; the model predicts the state after the edge
    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        exp_t e;
        bit   m_full, m_empty, r_ok, w_ok;
        bus.wr      = w;
        bus.rd      = r;
        bus.data_in = d;
        @(posedge clk);
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        r_ok    = r && !m_empty;
        w_ok    = w && (!m_full || r_ok);
        e.ov    = w && m_full && !r_ok;
        e.un    = r && m_empty;
        if (r_ok) mdout = mq.pop_front();
        if (w_ok) mq.push_back(d);
        e.count = mq.size();
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.af    = (mq.size() >= AF);
        e.ae    = (mq.size() <= AE);
`ifdef SYNC_FIFO_FWFT_EN
        e.dchk  = (mq.size() != 0);
        e.data  = e.dchk ? mq[0] : 8'h00;
`else
        e.dchk  = 1'b1;
        e.data  = mdout;
`endif
        expq.push_back(e);
        #1;
    endtask

    task automatic check_reset();
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_ae",    int'(bus.almost_empty), 1);
        check("rst_full",  int'(bus.full), 0);
        check("rst_af",    int'(bus.almost_full), 0);
        check("rst_ov",    int'(bus.overflow), 0);
        check("rst_un",    int'(bus.underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_data",  int'(bus.data_out), 0);
`endif
    endtask

    // Monitor: compares each predicted state on the falling edge after it
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("count",        int'(bus.count),        e.count);
            check("full",         int'(bus.full),         int'(e.full));
            check("empty",        int'(bus.empty),        int'(e.empty));
            check("almost_full",  int'(bus.almost_full),  int'(e.af));
            check("almost_empty", int'(bus.almost_empty), int'(e.ae));
            check("overflow",     int'(bus.overflow),     int'(e.ov));
            check("underflow",    int'(bus.underflow),    int'(e.un));
            if (e.dchk) check("data_out", int'(bus.data_out), int'(e.data));
        end
    end

    task automatic random_block(input int n, input int wbias, input int rbias);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(99) < wbias, $urandom_range(99) < rbias,
                  8'($urandom_range(255)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.data_in = 8'h00;
        mdout       = 8'h00;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Three words in, three out, then an idle cycle
        cycle(1, 0, 8'd10);
        cycle(1, 0, 8'd20);
        cycle(1, 0, 8'd30);
        cycle(0, 1, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Read while empty, including with a simultaneous write
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);
        cycle(1, 1, 8'h77);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Fill, overflow, simultaneous write+read while full, drain
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h40 + i));
        cycle(1, 0, 8'hAA);
        cycle(1, 1, 8'h99);
        for (int i = 0; i < 9; i++) cycle(0, 1, 8'h00);

        // Interleaved traffic across the pointer wrap
        for (int i = 0; i < 20; i++) cycle(1, (i % 3) != 0, 8'(8'h80 + i));
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);

        random_block(60, 80, 30);
        random_block(60, 30, 80);
        random_block(60, 60, 60);

        // Asynchronous reset in the middle of a burst
        random_block(5, 90, 20);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset();
        mq.delete();
        mdout = 8'h00;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        cycle(1, 0, 8'h55);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);
        random_block(80, 55, 50);
        cycle(0, 0, 8'h00);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 4.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_THRESH, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports wr and rd, each input, 1 bit: write request and read request.
REQ-008 SHALL have port data_in, input, WIDTH bits: write data.
REQ-009 SHALL have port data_out, output, WIDTH bits: read data.
REQ-010 SHALL have ports full and empty, each output, 1 bit: occupancy status.
REQ-011 SHALL have ports almost_full and almost_empty, each output, 1 bit: threshold status.
REQ-012 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy, 0 to DEPTH.
REQ-013 SHALL have ports overflow and underflow, each output, 1 bit: one-cycle error pulses.

Function
REQ-014 SHALL accept a write iff wr=1 and (full=0 or an accepted read occurs in the same cycle); the accepted write stores data_in at the write pointer.
REQ-015 SHALL accept a read iff rd=1 and empty=0; the accepted read advances the read pointer.
REQ-016 SHALL use read and write pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit, and the pointers wrap from DEPTH-1 to 0 with the wrap bit toggled.
REQ-017 SHALL assert full when the pointers differ only in the wrap bit, and empty when the pointers are equal; both are registered, with no combinational path from wr or rd.
REQ-018 SHALL update count as +1 on write only, -1 on read only, and unchanged on simultaneous accepted read and write or on neither.
REQ-019 SHALL assert almost_full when count >= AF_THRESH and almost_empty when count <= AE_THRESH; both are registered and consistent with count in the same cycle.
REQ-020 SHALL, on rd=1 while empty=1 (including simultaneous wr), ignore the read and pulse underflow for one cycle in the next cycle; the pointers are unchanged.
REQ-021 SHALL, on wr=1 while full=1 without an accepted read, drop the write and pulse overflow for one cycle; the stored contents are unchanged.
REQ-022 SHALL, in standard mode, load data_out with the head word on the clock edge of the accepted read (one-cycle latency), and hold data_out when no read is accepted.

Reset
REQ-023 SHALL, while rst=0, asynchronously force: pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-024 SHALL, on reset mid-operation, discard all stored entries; memory contents need not be cleared.
REQ-025 SHALL ignore wr and rd on the first rising edge after reset deasserts only if rst is still low at that edge.

Configuration
REQ-026 SHALL, with macro SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: data_out combinationally shows the head entry whenever empty=0, and an accepted read pops it with zero latency.
REQ-027 SHALL, in FWFT mode, drive data_out as a don't-care value while empty=1; a write to an empty FIFO becomes visible on data_out in the following cycle.
REQ-028 SHALL, without SYNC_FIFO_FWFT_EN, use the registered one-cycle read latency of REQ-022.

Structure
REQ-029 SHALL take the pointer-width function (clog2) and the default threshold constants from the shared package fifo_pkg.
REQ-030 SHALL place storage in one sub-module, fifo_ram: a simple dual-port RAM with one synchronous write port and one asynchronous read port, WIDTH x DEPTH.

Verification (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-031 SHALL cover: reset, then write 10,20,30, then read 3 -> data_out 10,20,30 in order (standard mode: one cycle after each accepted read); empty=1 after the last read; count sequence 1,2,3,2,1,0.
REQ-032 SHALL cover: write 8 words 0x40..0x47 -> almost_full rises when count=6, full=1 when count=8; a 9th write -> overflow pulse, and read-back gives 0x40..0x47.
REQ-033 SHALL cover: rd=1 on an empty FIFO -> underflow pulse, count stays 0, data_out unchanged.
REQ-034 SHALL cover: with the FIFO full, assert wr and rd together with data_in=0x99 -> no overflow, count stays 8, and 0x99 is returned last.
REQ-035 SHALL cover: 20 writes interleaved with reads across pointer wrap -> data order preserved; then assert rst=0 mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
REQ-036 SHALL cover: build with SYNC_FIFO_FWFT_EN, write 0x55 to an empty FIFO -> data_out=0x55 and empty=0 the next cycle; rd pops it with empty=1 the cycle after.
